axi4_rd_arbiter: RTL and testbench
==================================

Name: axi4_rd_arbiter

Overview:
Shares the single AXI4 read channel of the DDR controller between two read requesters. Port 0 is the high-priority video framebuffer fetch. Port 1 is the CPU/audio read path. Fixed priority goes to port 0, and a starvation counter guarantees port 1 a grant. Exactly one burst is outstanding at a time, and the grant is held until the final beat of that burst completes.

Parameters:
STARVE_MAX, 4, consecutive port-0 grants allowed while port 1 waits before port 1 is forced (legal range 1..255)
ADDR_W, 32, address width

Ports:
clk_i  in  1  system clock (DDR user clock)
rst_i  in  1  synchronous active-high reset
inportN_arvalid_i (N=0,1)  in  1  read request valid
inportN_araddr_i  in  ADDR_W  burst start address
inportN_arid_i  in  4  transaction ID
inportN_arlen_i  in  8  beats-1
inportN_arburst_i  in  2  burst type, forwarded unchanged
inportN_arready_o  out  1  request accepted
inportN_rvalid_o  out  1  read beat valid
inportN_rdata_o  out  32  read data
inportN_rresp_o  out  2  read response
inportN_rid_o  out  4  read ID
inportN_rlast_o  out  1  last beat
inportN_rready_i  in  1  requester accepts beat
outport_arvalid_o  out  1  to DDR
outport_araddr_o  out  ADDR_W  to DDR
outport_arid_o  out  4  to DDR
outport_arlen_o  out  8  to DDR
outport_arburst_o  out  2  to DDR
outport_arready_i  in  1  from DDR
outport_rvalid_i  in  1  from DDR
outport_rdata_i  in  32  from DDR
outport_rresp_i  in  2  from DDR
outport_rid_i  in  4  from DDR
outport_rlast_i  in  1  from DDR
outport_rready_o  out  1  to DDR

Behaviour:
- Reset state:
  - FSM goes to IDLE; grant register = 0; starvation counter = 0.
  - outport_arvalid_o = 0; all outport AR fields = 0; outport_rready_o = 0.
  - All inport arready/rvalid/rlast outputs = 0.
- FSM has three states: IDLE, ADDR, DATA.
- IDLE:
  - Arbitration is combinational on the arvalid inputs.
  - Winner selection:
    - Only one port valid: that port wins.
    - Both valid: port 1 wins if starve_cnt == STARVE_MAX, else port 0 wins.
  - The winner's arready_o is driven high for that single cycle, so the request is accepted in the same cycle.
  - The winner's addr/id/len/burst are registered into the outport_ar* outputs, and the winner is registered as grant.
  - Next state is ADDR.
  - No valid request: stay in IDLE, and all arready = 0.
- Starvation counter:
  - Port 0 wins while port 1 is valid: starve_cnt increments, saturating at STARVE_MAX.
  - Port 1 wins: starve_cnt clears to 0.
  - Port 0 wins with port 1 not valid: starve_cnt is unchanged.
- ADDR:
  - outport_arvalid_o = 1.
  - The AR payload is held stable until outport_arready_i is sampled high; then arvalid drops and the FSM moves to DATA.
  - A stall of any length is legal.
  - No inport arready is asserted.
- DATA, read channel routing:
  - The granted port's rvalid/rdata/rresp/rid/rlast are driven combinationally from the outport R inputs.
  - outport_rready_o = the granted port's rready_i.
  - The non-granted port sees rvalid = 0, rlast = 0, with data don't-care.
  - Burst end: outport_rvalid_i && outport_rready_o && outport_rlast_i moves the FSM to IDLE.
  - Re-arbitration happens in the following IDLE cycle, so there is one idle cycle between bursts.
- Outside DATA:
  - outport_rready_o = 0.
  - Any stray outport_rvalid_i is not forwarded.
- Beat count is not checked. rlast alone terminates the grant, and arlen is not compared.
- arvalid deasserted by a requester before acceptance is ignored; the protocol is the requester's responsibility.
- Arbitration and accept in IDLE happen in the same cycle, so a request present in IDLE is never lost.
- Reset mid-operation:
  - The arbiter returns to IDLE immediately and abandons any in-flight burst.
  - The DDR controller must be reset in the same cycle; no beats are drained.
- Latency:
  - inport arvalid high in IDLE → outport_arvalid_o high the next cycle.
  - R path adds zero cycles.

Test Plan:
1. Port 0 only: arvalid, addr 0x1000, len 3, id 2 → arready0 pulses 1 cycle; outport_araddr = 0x1000 and arvalid = 1 the next cycle; 4 beats routed to port 0, rid = 2; FSM returns to IDLE after rlast.
2. Port 1 only with outport_arready held low 5 cycles → outport AR payload stable for all 5 cycles; arready1 pulses only once.
3. Both ports continuously valid, STARVE_MAX = 4, len 0 → grant sequence 0,0,0,0,1,0,0,0,0,1.
4. Port 0 rready toggled 0/1 during an 8-beat burst → outport_rready mirrors it; port 1 rvalid = 0 throughout; exactly 8 beats delivered.
5. Spurious outport_rvalid_i pulse in IDLE → no inport rvalid asserted; outport_rready = 0.
6. rst_i asserted in DATA after beat 2 of 4 → next cycle all outputs = 0 and FSM in IDLE; a new port-1 request is granted immediately.

Source files
------------

// File: rtl/axi4_rd_arbiter_if.sv
// rtl/axi4_rd_arbiter_if.sv - two-requester AXI4 read bus bundle seen by the read arbiter
interface axi4_rd_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              inport0_arvalid_i;
   logic [ADDR_W-1:0] inport0_araddr_i;
   logic [3:0]        inport0_arid_i;
   logic [7:0]        inport0_arlen_i;
   logic [1:0]        inport0_arburst_i;
   logic              inport0_arready_o;
   logic              inport0_rvalid_o;
   logic [31:0]       inport0_rdata_o;
   logic [1:0]        inport0_rresp_o;
   logic [3:0]        inport0_rid_o;
   logic              inport0_rlast_o;
   logic              inport0_rready_i;

   logic              inport1_arvalid_i;
   logic [ADDR_W-1:0] inport1_araddr_i;
   logic [3:0]        inport1_arid_i;
   logic [7:0]        inport1_arlen_i;
   logic [1:0]        inport1_arburst_i;
   logic              inport1_arready_o;
   logic              inport1_rvalid_o;
   logic [31:0]       inport1_rdata_o;
   logic [1:0]        inport1_rresp_o;
   logic [3:0]        inport1_rid_o;
   logic              inport1_rlast_o;
   logic              inport1_rready_i;

   logic              outport_arvalid_o;
   logic [ADDR_W-1:0] outport_araddr_o;
   logic [3:0]        outport_arid_o;
   logic [7:0]        outport_arlen_o;
   logic [1:0]        outport_arburst_o;
   logic              outport_arready_i;
   logic              outport_rvalid_i;
   logic [31:0]       outport_rdata_i;
   logic [1:0]        outport_rresp_i;
   logic [3:0]        outport_rid_i;
   logic              outport_rlast_i;
   logic              outport_rready_o;

   // arbiter side
   modport slave (
      input  inport0_arvalid_i, inport0_araddr_i, inport0_arid_i, inport0_arlen_i,
             inport0_arburst_i, inport0_rready_i,
      output inport0_arready_o, inport0_rvalid_o, inport0_rdata_o, inport0_rresp_o,
             inport0_rid_o, inport0_rlast_o,
      input  inport1_arvalid_i, inport1_araddr_i, inport1_arid_i, inport1_arlen_i,
             inport1_arburst_i, inport1_rready_i,
      output inport1_arready_o, inport1_rvalid_o, inport1_rdata_o, inport1_rresp_o,
             inport1_rid_o, inport1_rlast_o,
      output outport_arvalid_o, outport_araddr_o, outport_arid_o, outport_arlen_o,
             outport_arburst_o, outport_rready_o,
      input  outport_arready_i, outport_rvalid_i, outport_rdata_i, outport_rresp_i,
             outport_rid_i, outport_rlast_i
   );

   // requesters plus DDR side, as driven by an environment
   modport master (
      output inport0_arvalid_i, inport0_araddr_i, inport0_arid_i, inport0_arlen_i,
             inport0_arburst_i, inport0_rready_i,
      input  inport0_arready_o, inport0_rvalid_o, inport0_rdata_o, inport0_rresp_o,
             inport0_rid_o, inport0_rlast_o,
      output inport1_arvalid_i, inport1_araddr_i, inport1_arid_i, inport1_arlen_i,
             inport1_arburst_i, inport1_rready_i,
      input  inport1_arready_o, inport1_rvalid_o, inport1_rdata_o, inport1_rresp_o,
             inport1_rid_o, inport1_rlast_o,
      input  outport_arvalid_o, outport_araddr_o, outport_arid_o, outport_arlen_o,
             outport_arburst_o, outport_rready_o,
      output outport_arready_i, outport_rvalid_i, outport_rdata_i, outport_rresp_i,
             outport_rid_i, outport_rlast_i
   );
endinterface

// File: rtl/axi4_rd_arbiter.sv
// rtl/axi4_rd_arbiter.sv - two-port AXI4 read arbiter, fixed priority with port-1 starvation guard
module axi4_rd_arbiter #(
   parameter int STARVE_MAX = 4,
   parameter int ADDR_W     = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   axi4_rd_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   state_t            state_q, state_d;
   logic              grant_q, grant_d;
   logic [7:0]        starve_q, starve_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic [3:0]        arid_q, arid_d;
   logic [7:0]        arlen_q, arlen_d;
   logic [1:0]        arburst_q, arburst_d;
   logic              win_valid;
   logic              win_sel;
   logic              rready_sel;

   // Pick a winner from the live requests; port 1 only beats port 0 once it has starved
   always_comb begin
      win_valid = bus.inport0_arvalid_i | bus.inport1_arvalid_i;
      win_sel   = 1'b0;
      if (bus.inport0_arvalid_i && bus.inport1_arvalid_i) begin
         win_sel = (starve_q == STARVE_LIM);
      end else begin
         win_sel = bus.inport1_arvalid_i;
      end
   end

   // Next state, grant/payload capture, starvation bookkeeping and AR/R handshake strobes
   always_comb begin
      state_d               = state_q;
      grant_d               = grant_q;
      starve_d              = starve_q;
      araddr_d              = araddr_q;
      arid_d                = arid_q;
      arlen_d               = arlen_q;
      arburst_d             = arburst_q;
      rready_sel            = grant_q ? bus.inport1_rready_i : bus.inport0_rready_i;
      bus.inport0_arready_o = 1'b0;
      bus.inport1_arready_o = 1'b0;
      bus.outport_arvalid_o = 1'b0;
      bus.outport_rready_o  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (win_valid) begin
               grant_d = win_sel;
               state_d = ADDR;
               if (win_sel) begin
                  bus.inport1_arready_o = 1'b1;
                  araddr_d              = bus.inport1_araddr_i;
                  arid_d                = bus.inport1_arid_i;
                  arlen_d               = bus.inport1_arlen_i;
                  arburst_d             = bus.inport1_arburst_i;
                  starve_d              = 8'd0;
               end else begin
                  bus.inport0_arready_o = 1'b1;
                  araddr_d              = bus.inport0_araddr_i;
                  arid_d                = bus.inport0_arid_i;
                  arlen_d               = bus.inport0_arlen_i;
                  arburst_d             = bus.inport0_arburst_i;
                  if (bus.inport1_arvalid_i) begin
                     starve_d = (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + 8'd1;
                  end
               end
            end
         end
         ADDR: begin
            bus.outport_arvalid_o = 1'b1;
            if (bus.outport_arready_i) begin
               state_d = DATA;
            end
         end
         DATA: begin
            bus.outport_rready_o = rready_sel;
            if (bus.outport_rvalid_i && rready_sel && bus.outport_rlast_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Beats go only to the granted port and only while its burst is in flight
   always_comb begin
      bus.inport0_rvalid_o = 1'b0;
      bus.inport0_rlast_o  = 1'b0;
      bus.inport1_rvalid_o = 1'b0;
      bus.inport1_rlast_o  = 1'b0;
      bus.inport0_rdata_o  = bus.outport_rdata_i;
      bus.inport0_rresp_o  = bus.outport_rresp_i;
      bus.inport0_rid_o    = bus.outport_rid_i;
      bus.inport1_rdata_o  = bus.outport_rdata_i;
      bus.inport1_rresp_o  = bus.outport_rresp_i;
      bus.inport1_rid_o    = bus.outport_rid_i;
      if (state_q == DATA) begin
         if (grant_q) begin
            bus.inport1_rvalid_o = bus.outport_rvalid_i;
            bus.inport1_rlast_o  = bus.outport_rlast_i;
         end else begin
            bus.inport0_rvalid_o = bus.outport_rvalid_i;
            bus.inport0_rlast_o  = bus.outport_rlast_i;
         end
      end
   end

   assign bus.outport_araddr_o  = araddr_q;
   assign bus.outport_arid_o    = arid_q;
   assign bus.outport_arlen_o   = arlen_q;
   assign bus.outport_arburst_o = arburst_q;

   // State, grant and captured AR payload; reset abandons any burst in flight
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         grant_q   <= 1'b0;
         starve_q  <= 8'd0;
         araddr_q  <= '0;
         arid_q    <= 4'd0;
         arlen_q   <= 8'd0;
         arburst_q <= 2'd0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         starve_q  <= starve_d;
         araddr_q  <= araddr_d;
         arid_q    <= arid_d;
         arlen_q   <= arlen_d;
         arburst_q <= arburst_d;
      end
   end
endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// tb/tb_axi4_rd_arbiter.sv - self-checking bench for the two-port AXI4 read arbiter
module tb_axi4_rd_arbiter;
   localparam int STARVE_MAX = 4;
   localparam int ADDR_W     = 32;

   typedef struct {
      bit                v0;
      bit                v1;
      logic [ADDR_W-1:0] a0;
      logic [ADDR_W-1:0] a1;
      logic [3:0]        id0;
      logic [3:0]        id1;
      int                l0;
      int                l1;
      bit                exp_g;
   } vec_t;

   logic clk_i = 1'b0;
   logic rst_i;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   starve_m;
   vec_t vecs[12];
   bit   exp3[10];

   always #5 clk_i = ~clk_i;

   axi4_rd_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   axi4_rd_arbiter #(.STARVE_MAX(STARVE_MAX), .ADDR_W(ADDR_W)) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .bus  (bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic nxt();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      bus.inport0_arvalid_i = 1'b0; bus.inport0_araddr_i = '0; bus.inport0_arid_i = 4'd0;
      bus.inport0_arlen_i = 8'd0; bus.inport0_arburst_i = 2'd0; bus.inport0_rready_i = 1'b0;
      bus.inport1_arvalid_i = 1'b0; bus.inport1_araddr_i = '0; bus.inport1_arid_i = 4'd0;
      bus.inport1_arlen_i = 8'd0; bus.inport1_arburst_i = 2'd0; bus.inport1_rready_i = 1'b0;
      bus.outport_arready_i = 1'b0; bus.outport_rvalid_i = 1'b0; bus.outport_rdata_i = 32'd0;
      bus.outport_rresp_i = 2'd0; bus.outport_rid_i = 4'd0; bus.outport_rlast_i = 1'b0;
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_arvalid_o"}, 64'(bus.outport_arvalid_o), 64'd0);
      check({tag, "_araddr_o"},  64'(bus.outport_araddr_o),  64'd0);
      check({tag, "_arid_o"},    64'(bus.outport_arid_o),    64'd0);
      check({tag, "_arlen_o"},   64'(bus.outport_arlen_o),   64'd0);
      check({tag, "_arburst_o"}, 64'(bus.outport_arburst_o), 64'd0);
      check({tag, "_rready_o"},  64'(bus.outport_rready_o),  64'd0);
      check({tag, "_arready"},   64'({bus.inport1_arready_o, bus.inport0_arready_o}), 64'd0);
      check({tag, "_rvalid"},    64'({bus.inport1_rvalid_o, bus.inport0_rvalid_o}), 64'd0);
      check({tag, "_rlast"},     64'({bus.inport1_rlast_o, bus.inport0_rlast_o}), 64'd0);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      clear_inputs();
      nxt();
      nxt();
      rst_i = 1'b0;
   endtask

   // entered at the start of an IDLE cycle with the requests already driven
   task automatic ar_phase(input bit g, input logic [ADDR_W-1:0] addr, input logic [3:0] id,
                           input int len, input logic [1:0] burst, input int stall);
      #1;
      check("idle_arready0", 64'(bus.inport0_arready_o), 64'(g == 1'b0));
      check("idle_arready1", 64'(bus.inport1_arready_o), 64'(g == 1'b1));
      check("idle_arvalid_o", 64'(bus.outport_arvalid_o), 64'd0);
      nxt();
      for (int c = 0; c <= stall; c++) begin
         bus.outport_arready_i = (c == stall);
         #1;
         check("addr_arvalid_o", 64'(bus.outport_arvalid_o), 64'd1);
         check("addr_araddr_o",  64'(bus.outport_araddr_o),  64'(addr));
         check("addr_arid_o",    64'(bus.outport_arid_o),    64'(id));
         check("addr_arlen_o",   64'(bus.outport_arlen_o),   64'(len));
         check("addr_arburst_o", 64'(bus.outport_arburst_o), 64'(burst));
         check("addr_arready",   64'({bus.inport1_arready_o, bus.inport0_arready_o}), 64'd0);
         check("addr_rready_o",  64'(bus.outport_rready_o), 64'd0);
         nxt();
      end
      bus.outport_arready_i = 1'b0;
   endtask

   // mode 0: random rvalid/rready; mode 1: rvalid held, granted rready toggles 0/1
   task automatic r_phase(input bit g, input logic [3:0] id, input int len, input int nbeats,
                          input int mode, output int delivered);
      int   sent;
      int   cyc;
      logic rv, rr, gv, ngv, ngl, gl;
      logic [31:0] gd;
      logic [3:0]  gid;
      logic [1:0]  gresp;
      sent = 0;
      cyc = 0;
      delivered = 0;
      while (sent < nbeats && cyc < 300) begin
         rv = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
         rr = (mode == 1) ? cyc[0] : ($urandom_range(0, 3) != 0);
         bus.outport_rvalid_i = rv;
         bus.outport_rdata_i  = $urandom;
         bus.outport_rresp_i  = 2'($urandom_range(0, 3));
         bus.outport_rid_i    = id;
         bus.outport_rlast_i  = (sent == len);
         bus.inport0_rready_i = g ? 1'($urandom_range(0, 1)) : rr;
         bus.inport1_rready_i = g ? rr : 1'($urandom_range(0, 1));
         #1;
         gv    = g ? bus.inport1_rvalid_o : bus.inport0_rvalid_o;
         gl    = g ? bus.inport1_rlast_o  : bus.inport0_rlast_o;
         gd    = g ? bus.inport1_rdata_o  : bus.inport0_rdata_o;
         gid   = g ? bus.inport1_rid_o    : bus.inport0_rid_o;
         gresp = g ? bus.inport1_rresp_o  : bus.inport0_rresp_o;
         ngv   = g ? bus.inport0_rvalid_o : bus.inport1_rvalid_o;
         ngl   = g ? bus.inport0_rlast_o  : bus.inport1_rlast_o;
         check("r_rvalid_granted", 64'(gv), 64'(rv));
         check("r_rvalid_other",   64'(ngv), 64'd0);
         check("r_rlast_other",    64'(ngl), 64'd0);
         check("r_rready_o",       64'(bus.outport_rready_o), 64'(rr));
         if (rv) begin
            check("r_rdata", 64'(gd), 64'(bus.outport_rdata_i));
            check("r_rid",   64'(gid), 64'(id));
            check("r_rresp", 64'(gresp), 64'(bus.outport_rresp_i));
            check("r_rlast", 64'(gl), 64'(sent == len));
         end
         if (gv && rr) delivered++;
         if (rv && rr) sent++;
         cyc++;
         nxt();
      end
      if (sent < nbeats) check("r_phase_timeout", 64'(sent), 64'(nbeats));
      bus.outport_rvalid_i = 1'b0;
      bus.outport_rlast_i  = 1'b0;
      bus.inport0_rready_i = 1'b0;
      bus.inport1_rready_i = 1'b0;
   endtask

   task automatic run_txn(input bit v0, input bit v1, input logic [ADDR_W-1:0] a0,
                          input logic [ADDR_W-1:0] a1, input logic [3:0] id0,
                          input logic [3:0] id1, input int l0, input int l1,
                          input bit exp_g, input int stall, input int mode);
      int d;
      bus.inport0_arvalid_i = v0; bus.inport0_araddr_i = a0; bus.inport0_arid_i = id0;
      bus.inport0_arlen_i = 8'(l0); bus.inport0_arburst_i = 2'b01;
      bus.inport1_arvalid_i = v1; bus.inport1_araddr_i = a1; bus.inport1_arid_i = id1;
      bus.inport1_arlen_i = 8'(l1); bus.inport1_arburst_i = 2'b10;
      ar_phase(exp_g, exp_g ? a1 : a0, exp_g ? id1 : id0, exp_g ? l1 : l0,
               exp_g ? 2'b10 : 2'b01, stall);
      r_phase(exp_g, exp_g ? id1 : id0, exp_g ? l1 : l0, (exp_g ? l1 : l0) + 1, mode, d);
      check("beats_delivered", 64'(d), 64'((exp_g ? l1 : l0) + 1));
   endtask

   // idle cycle with no requests and a stray DDR beat: nothing may leak through
   task automatic check_idle(input string tag);
      bus.inport0_arvalid_i = 1'b0;
      bus.inport1_arvalid_i = 1'b0;
      bus.outport_rvalid_i  = 1'b1;
      bus.outport_rlast_i   = 1'b1;
      bus.inport0_rready_i  = 1'b1;
      bus.inport1_rready_i  = 1'b1;
      #1;
      check({tag, "_rvalid"},    64'({bus.inport1_rvalid_o, bus.inport0_rvalid_o}), 64'd0);
      check({tag, "_rlast"},     64'({bus.inport1_rlast_o, bus.inport0_rlast_o}), 64'd0);
      check({tag, "_rready_o"},  64'(bus.outport_rready_o), 64'd0);
      check({tag, "_arready"},   64'({bus.inport1_arready_o, bus.inport0_arready_o}), 64'd0);
      check({tag, "_arvalid_o"}, 64'(bus.outport_arvalid_o), 64'd0);
      nxt();
      bus.outport_rvalid_i = 1'b0;
      bus.outport_rlast_i  = 1'b0;
      bus.inport0_rready_i = 1'b0;
      bus.inport1_rready_i = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d;
      // expected grants after port-1 wins leave the starvation count at 0
      vecs[0]  = '{1'b1, 1'b0, 32'h0000_2000, 32'h0000_9000, 4'h1, 4'h9, 1, 2, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 32'h0000_2100, 32'h0000_9100, 4'h2, 4'hA, 0, 1, 1'b1};
      vecs[2]  = '{1'b1, 1'b1, 32'h0000_2200, 32'h0000_9200, 4'h3, 4'hB, 2, 0, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 32'h0000_2300, 32'h0000_9300, 4'h4, 4'hC, 0, 0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 32'h0000_2400, 32'h0000_9400, 4'h5, 4'hD, 1, 1, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 32'h0000_2500, 32'h0000_9500, 4'h6, 4'hE, 0, 3, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 32'h0000_2600, 32'h0000_9600, 4'h7, 4'hF, 1, 0, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 32'h0000_2700, 32'h0000_9700, 4'h8, 4'h0, 0, 0, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 32'h0000_2800, 32'h0000_9800, 4'h9, 4'h1, 0, 2, 1'b1};
      vecs[9]  = '{1'b1, 1'b1, 32'h0000_2900, 32'h0000_9900, 4'hA, 4'h2, 3, 0, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 32'h0000_2A00, 32'h0000_9A00, 4'hB, 4'h3, 0, 1, 1'b1};
      vecs[11] = '{1'b1, 1'b1, 32'h0000_2B00, 32'h0000_9B00, 4'hC, 4'h4, 2, 1, 1'b0};
      exp3 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      rst_i = 1'b1;
      clear_inputs();
      nxt();
      nxt();
      check_zero_outputs("reset");
      rst_i = 1'b0;

      // port 0 alone, then the bus must be idle again
      run_txn(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'd2, 4'd0, 3, 0, 1'b0, 0, 0);
      check_idle("after_p0");

      // port 1 alone with the DDR stalling AR for 5 cycles
      run_txn(1'b0, 1'b1, 32'h0, 32'h0000_5A00, 4'd0, 4'd7, 0, 1, 1'b1, 5, 0);

      // both ports always requesting, single-beat bursts
      for (int k = 0; k < 10; k++) begin
         run_txn(1'b1, 1'b1, 32'h100 + 32'(k), 32'h200 + 32'(k), 4'(k), 4'(k + 5), 0, 0,
                 exp3[k], 0, 0);
      end

      for (int i = 0; i < 12; i++) begin
         run_txn(vecs[i].v0, vecs[i].v1, vecs[i].a0, vecs[i].a1, vecs[i].id0, vecs[i].id1,
                 vecs[i].l0, vecs[i].l1, vecs[i].exp_g, i % 3, 0);
      end

      // 8-beat burst with port 0 rready toggling
      run_txn(1'b1, 1'b0, 32'h0000_8000, 32'h0, 4'd4, 4'd0, 7, 0, 1'b0, 1, 1);

      // stray DDR beat while idle
      check_idle("stray");

      // randomized traffic against the arbitration rules
      do_reset();
      starve_m = 0;
      for (int k = 0; k < 40; k++) begin
         int sel;
         bit rv0, rv1, g;
         sel = $urandom_range(1, 3);
         rv0 = sel[0];
         rv1 = sel[1];
         if (rv0 && rv1) g = (starve_m == STARVE_MAX);
         else g = rv1;
         if (g) starve_m = 0;
         else if (rv1) starve_m = (starve_m < STARVE_MAX) ? starve_m + 1 : STARVE_MAX;
         run_txn(rv0, rv1, $urandom, $urandom, 4'($urandom), 4'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 3), g, $urandom_range(0, 3), 0);
      end

      // reset in the middle of a 4-beat burst, after 2 beats
      bus.inport0_arvalid_i = 1'b1; bus.inport0_araddr_i = 32'h0000_7700;
      bus.inport0_arid_i = 4'd6; bus.inport0_arlen_i = 8'd3; bus.inport0_arburst_i = 2'b01;
      bus.inport1_arvalid_i = 1'b0;
      ar_phase(1'b0, 32'h0000_7700, 4'd6, 3, 2'b01, 0);
      bus.inport0_arvalid_i = 1'b0;
      r_phase(1'b0, 4'd6, 3, 2, 0, d);
      check("pre_reset_beats", 64'(d), 64'd2);
      rst_i = 1'b1;
      bus.outport_rvalid_i = 1'b1;
      bus.inport0_rready_i = 1'b1;
      nxt();
      rst_i = 1'b0;
      #1;
      check_zero_outputs("midreset");
      bus.outport_rvalid_i = 1'b0;
      bus.inport0_rready_i = 1'b0;
      run_txn(1'b0, 1'b1, 32'h0, 32'h0000_3300, 4'd0, 4'd3, 0, 2, 1'b1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
